// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared word type, width and state encoding for the serial wide adder
package bk_pkg;

   localparam int BK_W = 16;

   typedef logic [BK_W-1:0] bk_word_t;

   // Packet position: IDLE waits for a first word, RUN is mid-packet.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } bk_state_t;

endpackage

// File: rtl/bk_serial_wide_adder_if.sv
// rtl/bk_serial_wide_adder_if.sv - operand-in / sum-out handshake bundle
interface bk_serial_wide_adder_if;
   import bk_pkg::*;

   logic     s_clear;
   logic     s_valid;
   logic     s_ready;
   bk_word_t s_a;
   bk_word_t s_b;
   logic     s_sub;

   logic     m_valid;
   logic     m_ready;
   bk_word_t m_sum;
   logic     m_last;
   logic     m_cout;
   logic     m_ovf;

   // Operand source and result sink side.
   modport master (
      output s_clear, s_valid, s_a, s_b, s_sub, m_ready,
      input  s_ready, m_valid, m_sum, m_last, m_cout, m_ovf
   );

   // Adder engine side.
   modport slave (
      input  s_clear, s_valid, s_a, s_b, s_sub, m_ready,
      output s_ready, m_valid, m_sum, m_last, m_cout, m_ovf
   );

endinterface

// File: rtl/bk_add16.sv
// rtl/bk_add16.sv - combinational 16-bit Brent-Kung prefix adder with carry-in
module bk_add16
   import bk_pkg::*;
(
   input  bk_word_t a,
   input  bk_word_t b,
   input  logic     cin,
   output bk_word_t sum,
   output logic     cout,
   output logic     c15
);

   bk_word_t p;
   bk_word_t gp;   // group generate; after the sweeps gp[i] is the carry into bit i+1
   bk_word_t pp;   // group propagate, only meaningful for spans not reaching bit 0

   assign p = a ^ b;

   // Prefix tree: cin acts as a pure generate below bit 0, then 4 up-sweep and 3 down-sweep levels.
   always_comb begin
      gp    = a & b;
      pp    = p;
      gp[0] = gp[0] | (p[0] & cin);
      for (int l = 1; l <= 4; l++) begin
         for (int i = (1 << l) - 1; i < BK_W; i += (1 << l)) begin
            gp[i] = gp[i] | (pp[i] & gp[i - (1 << (l - 1))]);
            pp[i] = pp[i] & pp[i - (1 << (l - 1))];
         end
      end
      for (int k = 2; k >= 0; k--) begin
         for (int i = 3 * (1 << k) - 1; i < BK_W; i += (1 << (k + 1))) begin
            gp[i] = gp[i] | (pp[i] & gp[i - (1 << k)]);
         end
      end
   end

   assign sum  = p ^ {gp[BK_W-2:0], cin};
   assign cout = gp[BK_W-1];
   assign c15  = gp[BK_W-2];

endmodule

// File: rtl/bk_serial_wide_adder.sv
// rtl/bk_serial_wide_adder.sv - word-serial wide add/subtract with registered inter-word carry
module bk_serial_wide_adder
   import bk_pkg::*;
#(
   parameter int NUM_WORDS = 4,
   parameter int CNT_W     = 2
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   bk_serial_wide_adder_if.slave   io
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             m_valid_q, m_valid_d;
   bk_word_t         m_sum_q, m_sum_d;
   logic             m_last_q, m_last_d;
   logic             m_cout_q, m_cout_d;
   logic             m_ovf_q, m_ovf_d;

   bk_state_t        state;
   logic             accept;
   logic             is_last;
   logic             sub_eff;
   logic             cin;
   bk_word_t         b_eff;
   bk_word_t         sum;
   logic             cout16;
   logic             c15;

   // Packet position is carried entirely by the word counter.
   assign state   = (cnt_q == '0) ? ST_IDLE : ST_RUN;
   assign is_last = (cnt_q == LAST_CNT);

   // Clear has priority over any word offered in the same cycle.
   assign io.s_ready = (!m_valid_q || io.m_ready) && !io.s_clear;
   assign accept     = io.s_valid && io.s_ready;

   // A first word takes its mode straight from the port; later words reuse the latched mode and carry.
   assign sub_eff = (state == ST_IDLE) ? io.s_sub : sub_q;
   assign cin     = (state == ST_IDLE) ? io.s_sub : carry_q;
   assign b_eff   = sub_eff ? ~io.s_b : io.s_b;

   bk_add16 u_add (
      .a    (io.s_a),
      .b    (b_eff),
      .cin  (cin),
      .sum  (sum),
      .cout (cout16),
      .c15  (c15)
   );

   // Next-state: clear, accept of a word, or output drained with nothing new.
   always_comb begin
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      sub_d     = sub_q;
      m_valid_d = m_valid_q;
      m_sum_d   = m_sum_q;
      m_last_d  = m_last_q;
      m_cout_d  = m_cout_q;
      m_ovf_d   = m_ovf_q;
      if (io.s_clear) begin
         cnt_d     = '0;
         carry_d   = 1'b0;
         m_valid_d = 1'b0;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            sub_d = io.s_sub;
         end
         m_sum_d   = sum;
         carry_d   = cout16;
         m_valid_d = 1'b1;
         m_last_d  = is_last;
         if (is_last) begin
            m_cout_d = cout16;
            m_ovf_d  = c15 ^ cout16;
            cnt_d    = '0;
         end else begin
            m_cout_d = 1'b0;
            m_ovf_d  = 1'b0;
            cnt_d    = cnt_q + CNT_ONE;
         end
      end else if (io.m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         sub_q     <= 1'b0;
         m_valid_q <= 1'b0;
         m_sum_q   <= '0;
         m_last_q  <= 1'b0;
         m_cout_q  <= 1'b0;
         m_ovf_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         sub_q     <= sub_d;
         m_valid_q <= m_valid_d;
         m_sum_q   <= m_sum_d;
         m_last_q  <= m_last_d;
         m_cout_q  <= m_cout_d;
         m_ovf_q   <= m_ovf_d;
      end
   end

   assign io.m_valid = m_valid_q;
   assign io.m_sum   = m_sum_q;
   assign io.m_last  = m_last_q;
   assign io.m_cout  = m_cout_q;
   assign io.m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_bk_serial_wide_adder.sv
// tb/tb_bk_serial_wide_adder.sv - randomized and directed bench for the serial wide adder
module tb_bk_serial_wide_adder;

   localparam int NW = 4;

   typedef struct packed {
      logic [15:0] sum;
      logic        last;
      logic        cout;
      logic        ovf;
   } out_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] res;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   bk_serial_wide_adder_if bus ();

   bk_serial_wide_adder #(.NUM_WORDS(NW), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   out_t got_q[$];
   out_t exp_q[$];

   logic [63:0] ma, mb;
   logic        msub;
   int          mcnt = 0;

   // Golden 64-bit packet model fed by accepted words.
   task automatic model_accept(input logic [15:0] a, input logic [15:0] b, input logic sub);
      logic [64:0] wide;
      logic [63:0] res;
      logic        cout, ovf;
      if (mcnt == 0) msub = sub;
      ma[16*mcnt +: 16] = a;
      mb[16*mcnt +: 16] = b;
      mcnt++;
      if (mcnt == NW) begin
         if (msub) begin
            res  = ma - mb;
            cout = (ma >= mb);
            ovf  = (ma[63] != mb[63]) && (res[63] != ma[63]);
         end else begin
            wide = {1'b0, ma} + {1'b0, mb};
            res  = wide[63:0];
            cout = wide[64];
            ovf  = (ma[63] == mb[63]) && (res[63] != ma[63]);
         end
         for (int k = 0; k < NW; k++)
            exp_q.push_back('{res[16*k +: 16], (k == NW-1), (k == NW-1) && cout, (k == NW-1) && ovf});
         mcnt = 0;
      end
   endtask

   task automatic flush();
      got_q.delete();
      exp_q.delete();
      mcnt = 0;
   endtask

   // One clock of stimulus; observes handshakes at the falling edge.
   task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic mr, input logic clr, output logic acc);
      @(posedge clk);
      #1;
      bus.s_valid = v;
      bus.s_a     = a;
      bus.s_b     = b;
      bus.s_sub   = sub;
      bus.m_ready = mr;
      bus.s_clear = clr;
      @(negedge clk);
      acc = v && bus.s_ready;
      if (bus.m_valid && bus.m_ready)
         got_q.push_back('{bus.m_sum, bus.m_last, bus.m_cout, bus.m_ovf});
      if (acc) model_accept(a, b, sub);
      if (clr) mcnt = 0;
   endtask

   task automatic send_packet(input logic [63:0] A, input logic [63:0] B, input logic sub);
      int   k = 0;
      logic acc;
      for (int c = 0; c < 50 && k < NW; c++) begin
         cycle(1'b1, A[16*k +: 16], B[16*k +: 16], sub, 1'b1, 1'b0, acc);
         if (acc) k++;
      end
      checks++;
      if (k != NW) begin
         failures++;
         $display("FAIL send_packet words_accepted=%0d required=%0d", k, NW);
      end
      repeat (4) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.m_valid, bus.m_sum, bus.m_last, bus.m_cout, bus.m_ovf} !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", {bus.m_valid, bus.m_sum, bus.m_last, bus.m_cout, bus.m_ovf});
      end
      checks++;
      if (bus.s_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_s_ready got=%b required=1", bus.s_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_arith();
      vec_t tbl[3];
      tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
      tbl[1] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      for (int t = 0; t < 3; t++) begin
         flush();
         send_packet(tbl[t].a, tbl[t].b, tbl[t].sub);
         checks++;
         if (got_q.size() != NW) begin
            failures++;
            $display("FAIL arith%0d_words got=%0d required=%0d", t, got_q.size(), NW);
         end else begin
            for (int k = 0; k < NW; k++) begin
               checks++;
               if (got_q[k] !== out_t'{tbl[t].res[16*k +: 16], (k == NW-1),
                                       (k == NW-1) && tbl[t].cout, (k == NW-1) && tbl[t].ovf}) begin
                  failures++;
                  $display("FAIL arith%0d_word%0d got sum=%h last=%b cout=%b ovf=%b required sum=%h last=%b cout=%b ovf=%b",
                           t, k, got_q[k].sum, got_q[k].last, got_q[k].cout, got_q[k].ovf,
                           tbl[t].res[16*k +: 16], (k == NW-1), (k == NW-1) && tbl[t].cout, (k == NW-1) && tbl[t].ovf);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] A, B, res;
      logic        sub, acc;
      int          k;
      A   = {$urandom, $urandom};
      B   = {$urandom, $urandom};
      sub = 1'b1;
      res = A - B;
      flush();
      cycle(1'b1, A[15:0], B[15:0], sub, 1'b1, 1'b0, acc);
      k = acc ? 1 : 0;
      for (int h = 0; h < 3; h++) begin
         cycle(1'b1, A[16*k +: 16], B[16*k +: 16], sub, 1'b0, 1'b0, acc);
         if (acc) k++;
         checks++;
         if (acc !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_sum !== res[15:0]) begin
            failures++;
            $display("FAIL backpressure_hold%0d got s_ready=%b m_valid=%b m_sum=%h required s_ready=0 m_valid=1 m_sum=%h",
                     h, bus.s_ready, bus.m_valid, bus.m_sum, res[15:0]);
         end
      end
      for (int c = 0; c < 50 && k < NW; c++) begin
         cycle(1'b1, A[16*k +: 16], B[16*k +: 16], sub, 1'b1, 1'b0, acc);
         if (acc) k++;
      end
      repeat (4) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
      checks++;
      if (got_q.size() != NW || exp_q.size() != NW) begin
         failures++;
         $display("FAIL backpressure_words got=%0d required=%0d", got_q.size(), NW);
      end else begin
         for (int w = 0; w < NW; w++) begin
            checks++;
            if (got_q[w] !== exp_q[w] || got_q[w].sum !== res[16*w +: 16]) begin
               failures++;
               $display("FAIL backpressure_word%0d got=%h required=%h", w, got_q[w], exp_q[w]);
            end
         end
      end
   endtask

   task automatic test_abort();
      logic acc;
      flush();
      cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, acc);
      cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, acc);
      cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, 1'b1, acc);
      checks++;
      if (acc !== 1'b0) begin
         failures++;
         $display("FAIL abort_s_ready got=%b required=0", bus.s_ready);
      end
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
      flush();
      send_packet(64'h1, 64'h1, 1'b0);
      checks++;
      if (got_q.size() != NW) begin
         failures++;
         $display("FAIL abort_words got=%0d required=%0d", got_q.size(), NW);
      end else begin
         for (int k = 0; k < NW; k++) begin
            checks++;
            if (got_q[k].sum !== ((k == 0) ? 16'h0002 : 16'h0000) || got_q[k].last !== (k == NW-1)) begin
               failures++;
               $display("FAIL abort_word%0d got sum=%h last=%b required sum=%h last=%b",
                        k, got_q[k].sum, got_q[k].last, (k == 0) ? 16'h0002 : 16'h0000, (k == NW-1));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      flush();
      cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 16'h5555, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_sum !== 16'h2345) begin
         failures++;
         $display("FAIL pre_reset_word got valid=%b sum=%h required valid=1 sum=2345", bus.m_valid, bus.m_sum);
      end
      @(posedge clk);
      #3;
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      #1;
      checks++;
      if ({bus.m_valid, bus.m_sum, bus.m_last, bus.m_cout, bus.m_ovf} !== 20'h0) begin
         failures++;
         $display("FAIL async_reset_outputs got=%h required=0", {bus.m_valid, bus.m_sum, bus.m_last, bus.m_cout, bus.m_ovf});
      end
      @(negedge clk);
      rst_n = 1'b1;
      flush();
   endtask

   function automatic logic [15:0] pick_word();
      case ($urandom_range(0, 4))
         0:       return 16'hFFFF;
         1:       return 16'h0000;
         2:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_random(input int npkt);
      int   words = 0;
      logic acc;
      logic v, mr;
      for (int c = 0; c < 40000 && words < npkt * NW; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         mr = ($urandom_range(0, 3) != 0);
         cycle(v, pick_word(), pick_word(), 1'($urandom), mr, 1'b0, acc);
         if (acc) words++;
      end
      repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
      checks++;
      if (words != npkt * NW || got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL random_count words=%0d required=%0d got_out=%0d required_out=%0d",
                  words, npkt * NW, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL random_word%0d got sum=%h last=%b cout=%b ovf=%b required sum=%h last=%b cout=%b ovf=%b",
                     i, got_q[i].sum, got_q[i].last, got_q[i].cout, got_q[i].ovf,
                     exp_q[i].sum, exp_q[i].last, exp_q[i].cout, exp_q[i].ovf);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.s_a     = 16'h0;
      bus.s_b     = 16'h0;
      bus.s_sub   = 1'b0;
      bus.s_clear = 1'b0;
      bus.m_ready = 1'b0;
      test_reset();
      test_arith();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_random(1500);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
